// File: rtl/store_check_monitor.sv
// Store-stream checker: compares CPU data-memory writes against an in-order table of expected stores.
// Latency: a store sampled at edge N is reflected in status outputs after edge N; all outputs registered.
// Backpressure: none; one store evaluated per cycle, back-to-back stores accepted every cycle.
module store_check_monitor #(
    parameter int          DATA_W      = 32,
    parameter int          ADDR_W      = 32,
    parameter int          DEPTH       = 8,
    parameter int unsigned IGNORE_ADDR = 80,
    parameter int          TIMEOUT     = 1000,
    localparam int         IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int         CNT_W       = $clog2(DEPTH + 1),
    localparam int         CYC_W       = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_idx,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    input  logic [CNT_W-1:0]  prog_count,
    input  logic              start,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] dataadr,
    input  logic [DATA_W-1:0] writedata,
    output logic              busy,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  match_cnt,
    output logic [ADDR_W-1:0] err_adr,
    output logic [DATA_W-1:0] err_data,
    output logic [CYC_W-1:0]  cycles
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PASS = 2'd2,
        S_FAIL = 2'd3
    } state_t;

    localparam logic [1:0] CODE_ADDR    = 2'd1;
    localparam logic [1:0] CODE_DATA    = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT = 2'd3;

    state_t state;
    state_t state_next;

    // Expected-store table; contents are don't-care after reset so it carries no reset.
    logic [ADDR_W-1:0] exp_addr [DEPTH];
    logic [DATA_W-1:0] exp_data [DEPTH];

    logic [CNT_W-1:0]  run_count;
    logic [CNT_W-1:0]  cnt_clamped;
    logic              launch;
    logic [IDX_W-1:0]  cur_idx;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_data;
    logic              addr_hit;
    logic              store_ok;
    logic              final_match;
    logic              bad_data;
    logic              bad_addr;
    logic              timeout_hit;

    // Table write port, locked out while a run is checking against it.
    always_ff @(posedge clk) begin
        if (prog_we && state != S_RUN && (32'(prog_idx) < DEPTH)) begin
            exp_addr[prog_idx] <= prog_addr;
            exp_data[prog_idx] <= prog_data;
        end
    end

    // Evaluate the current store against the next expected entry and the watchdog.
    always_comb begin
        cnt_clamped = (prog_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : prog_count;
        launch      = start && (cnt_clamped != '0);
        // match_cnt stays below run_count (<= DEPTH) while running, so the slice is in range.
        cur_idx     = match_cnt[IDX_W-1:0];
        cur_addr    = exp_addr[cur_idx];
        cur_data    = exp_data[cur_idx];
        addr_hit    = memwrite && (dataadr == cur_addr);
        store_ok    = addr_hit && (writedata == cur_data);
        final_match = store_ok && ((match_cnt + 1'b1) == run_count);
        bad_data    = addr_hit && !store_ok;
        // An expected entry at the scratch address is already caught by addr_hit above.
        bad_addr    = memwrite && !addr_hit && (dataadr != ADDR_W'(IGNORE_ADDR));
        timeout_hit = (cycles == CYC_W'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: a final match beats any failure; store failures and timeout both end in FAIL.
    always_comb begin
        state_next = state;
        case (state)
            S_RUN: begin
                if (final_match) begin
                    state_next = S_PASS;
                end else if (bad_data || bad_addr || timeout_hit) begin
                    state_next = S_FAIL;
                end
            end
            default: begin
                if (launch) begin
                    state_next = S_RUN;
                end
            end
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        busy = (state == S_RUN);
    end

    // Run status: cleared on launch, updated per store while running, sticky afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_count <= '0;
            match_cnt <= '0;
            cycles    <= '0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            fail_code <= '0;
            err_adr   <= '0;
            err_data  <= '0;
        end else if (state != S_RUN) begin
            if (launch) begin
                run_count <= cnt_clamped;
                match_cnt <= '0;
                cycles    <= '0;
                pass      <= 1'b0;
                fail      <= 1'b0;
                fail_code <= '0;
                err_adr   <= '0;
                err_data  <= '0;
            end
        end else begin
            if (cycles != CYC_W'(TIMEOUT)) begin
                cycles <= cycles + 1'b1;
            end
            if (store_ok) begin
                match_cnt <= match_cnt + 1'b1;
            end
            if (final_match) begin
                pass <= 1'b1;
            end else if (bad_data) begin
                fail      <= 1'b1;
                fail_code <= CODE_DATA;
                err_adr   <= dataadr;
                err_data  <= writedata;
            end else if (bad_addr) begin
                fail      <= 1'b1;
                fail_code <= CODE_ADDR;
                err_adr   <= dataadr;
                err_data  <= writedata;
            end else if (timeout_hit) begin
                fail      <= 1'b1;
                fail_code <= CODE_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_store_check_monitor.sv
// Bench for store_check_monitor: directed test-plan scenarios plus randomized stores
// checked every cycle against a behavioural model of the expected-store rules.
module tb_store_check_monitor;

    localparam int DEPTH = 4;
    localparam int TO    = 16;
    localparam int IGN   = 80;
    localparam int IW    = 2;
    localparam int CW    = 3;
    localparam int YW    = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          prog_we;
    logic [IW-1:0] prog_idx;
    logic [31:0]   prog_addr;
    logic [31:0]   prog_data;
    logic [CW-1:0] prog_count;
    logic          start;
    logic          memwrite;
    logic [31:0]   dataadr;
    logic [31:0]   writedata;
    logic          busy;
    logic          pass;
    logic          fail;
    logic [1:0]    fail_code;
    logic [CW-1:0] match_cnt;
    logic [31:0]   err_adr;
    logic [31:0]   err_data;
    logic [YW-1:0] cycles;

    store_check_monitor #(
        .DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .IGNORE_ADDR(IGN), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .prog_we(prog_we), .prog_idx(prog_idx),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_count(prog_count),
        .start(start), .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
        .busy(busy), .pass(pass), .fail(fail), .fail_code(fail_code),
        .match_cnt(match_cnt), .err_adr(err_adr), .err_data(err_data), .cycles(cycles)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model: phase 0 idle, 1 running, 2 passed, 3 failed.
    int          m_st = 0;
    int          m_cnt = 0, m_mc = 0, m_cy = 0, m_pass = 0, m_fail = 0, m_fc = 0;
    logic [31:0] m_ea = 0, m_ed = 0;
    logic [31:0] ta [DEPTH];
    logic [31:0] td [DEPTH];

    function automatic void chk(string name, longint unsigned act, longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endfunction

    function automatic void m_failwith(int code, logic [31:0] a, logic [31:0] d, bit cap);
        m_st   = 3;
        m_fail = 1;
        m_fc   = code;
        if (cap) begin
            m_ea = a;
            m_ed = d;
        end
    endfunction

    // Model update from the inputs seen at each rising edge.
    always @(posedge clk) begin
        int  c;
        bit  done;
        if (m_st != 1 && prog_we) begin
            ta[prog_idx] = prog_addr;
            td[prog_idx] = prog_data;
        end
        if (reset) begin
            m_st = 0; m_cnt = 0; m_mc = 0; m_cy = 0;
            m_pass = 0; m_fail = 0; m_fc = 0; m_ea = 0; m_ed = 0;
        end else if (m_st == 1) begin
            done = 1'b0;
            if (memwrite) begin
                if (dataadr == ta[m_mc] && writedata == td[m_mc]) begin
                    m_mc++;
                    if (m_mc == m_cnt) begin
                        m_st = 2; m_pass = 1; done = 1'b1;
                    end
                end else if (dataadr == ta[m_mc]) begin
                    m_failwith(2, dataadr, writedata, 1'b1); done = 1'b1;
                end else if (dataadr != IGN) begin
                    m_failwith(1, dataadr, writedata, 1'b1); done = 1'b1;
                end
            end
            if (!done && m_cy == TO - 1) m_failwith(3, 0, 0, 1'b0);
            if (m_cy < TO) m_cy++;
        end else if (start) begin
            c = (int'(prog_count) > DEPTH) ? DEPTH : int'(prog_count);
            if (c > 0) begin
                m_st = 1; m_cnt = c; m_mc = 0; m_cy = 0;
                m_pass = 0; m_fail = 0; m_fc = 0; m_ea = 0; m_ed = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, (m_st == 1) ? 1 : 0);
            chk("pass", pass, m_pass);
            chk("fail", fail, m_fail);
            chk("fail_code", fail_code, m_fc);
            chk("match_cnt", match_cnt, m_mc);
            chk("err_adr", err_adr, m_ea);
            chk("err_data", err_data, m_ed);
            chk("cycles", cycles, m_cy);
        end
    end

    task automatic idle_in();
        reset = 0; prog_we = 0; start = 0; memwrite = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic prog(int idx, int a, int d);
        idle_in();
        prog_we = 1; prog_idx = IW'(idx); prog_addr = a; prog_data = d;
        tick();
        idle_in();
    endtask

    task automatic go(int n);
        idle_in();
        prog_count = CW'(n); start = 1;
        tick();
        idle_in();
    endtask

    task automatic store(int a, int d);
        idle_in();
        memwrite = 1; dataadr = a; writedata = d;
        tick();
        idle_in();
    endtask

    // Literal expectation applied to both the DUT and the model.
    task automatic lit(string nm, longint unsigned dv, longint unsigned mv, longint unsigned exp);
        chk({nm, "_dut"}, dv, exp);
        chk({nm, "_model"}, mv, exp);
    endtask

    function automatic logic [31:0] pick_addr();
        int unsigned k;
        k = $urandom_range(0, 6);
        case (k)
            0: return 32'd0;
            1: return 32'd4;
            2: return 32'd8;
            3: return 32'd12;
            4: return 32'd80;
            5: return 32'd84;
            default: return 32'd88;
        endcase
    endfunction

    initial begin
        idle_in();
        prog_idx = 0; prog_addr = 0; prog_data = 0; prog_count = 0;
        dataadr = 0; writedata = 0;
        reset = 1;
        tick();
        chk_en = 1'b1;
        tick();
        idle_in();
        lit("rst_busy", busy, (m_st == 1) ? 1 : 0, 0);
        lit("rst_cnt", match_cnt, m_mc, 0);
        lit("rst_cyc", cycles, m_cy, 0);

        prog(0, 84, 7); prog(1, 4, 2); prog(2, 8, 3); prog(3, 12, 4);

        // Ignored scratch store then the expected store.
        go(1);
        lit("t1_busy", busy, (m_st == 1) ? 1 : 0, 1);
        store(80, 5);
        lit("t1_mc0", match_cnt, m_mc, 0);
        store(84, 7);
        lit("t1_pass", pass, m_pass, 1);
        lit("t1_mc", match_cnt, m_mc, 1);
        lit("t1_code", fail_code, m_fc, 0);
        lit("t1_busy0", busy, (m_st == 1) ? 1 : 0, 0);

        // Data mismatch, then sticky.
        go(1);
        lit("t2_pass0", pass, m_pass, 0);
        store(84, 6);
        lit("t2_fail", fail, m_fail, 1);
        lit("t2_code", fail_code, m_fc, 2);
        lit("t2_eadr", err_adr, m_ea, 84);
        lit("t2_edat", err_data, m_ed, 6);
        store(84, 7);
        lit("t2_sticky", fail_code, m_fc, 2);
        lit("t2_mc", match_cnt, m_mc, 0);

        // Unexpected address, then restart clears status.
        go(1);
        store(88, 7);
        lit("t3_code", fail_code, m_fc, 1);
        lit("t3_eadr", err_adr, m_ea, 88);
        go(1);
        lit("t3_fail0", fail, m_fail, 0);
        lit("t3_eadr0", err_adr, m_ea, 0);
        store(84, 7);
        lit("t3_pass", pass, m_pass, 1);

        // Timeout exactly TO cycles after start.
        go(1);
        repeat (TO - 1) tick();
        lit("t4_fail0", fail, m_fail, 0);
        lit("t4_cyc15", cycles, m_cy, TO - 1);
        tick();
        lit("t4_fail", fail, m_fail, 1);
        lit("t4_code", fail_code, m_fc, 3);
        lit("t4_cyc", cycles, m_cy, TO);
        lit("t4_eadr", err_adr, m_ea, 0);

        // Final match in the timeout cycle wins.
        go(1);
        repeat (TO - 1) tick();
        store(84, 7);
        lit("t5_pass", pass, m_pass, 1);
        lit("t5_fail", fail, m_fail, 0);
        lit("t5_cyc", cycles, m_cy, TO);

        // Zero count start is ignored.
        go(0);
        lit("t0_busy", busy, (m_st == 1) ? 1 : 0, 0);
        lit("t0_pass", pass, m_pass, 1);

        // Reset mid-run, then a full three-entry run.
        prog(0, 0, 1);
        go(3);
        store(0, 1); store(4, 2);
        lit("t6_mc2", match_cnt, m_mc, 2);
        idle_in(); reset = 1; tick(); idle_in();
        lit("t6_busy", busy, (m_st == 1) ? 1 : 0, 0);
        lit("t6_mc0", match_cnt, m_mc, 0);
        go(3);
        store(0, 1); store(4, 2); store(8, 3);
        lit("t6_pass", pass, m_pass, 1);
        lit("t6_mc3", match_cnt, m_mc, 3);

        // Table writes during a run are ignored.
        go(3);
        prog(0, 0, 9);
        store(0, 1); store(4, 2); store(8, 3);
        lit("t7_pass", pass, m_pass, 1);

        // Count above DEPTH clamps to DEPTH.
        go(7);
        store(0, 1); store(4, 2); store(8, 3);
        lit("t8_busy", busy, (m_st == 1) ? 1 : 0, 1);
        store(12, 4);
        lit("t8_pass", pass, m_pass, 1);
        lit("t8_mc", match_cnt, m_mc, 4);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            idle_in();
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 5) == 0) begin
                prog_we = 1; prog_idx = IW'($urandom_range(0, 3));
                prog_addr = pick_addr(); prog_data = $urandom_range(0, 3);
            end
            if ($urandom_range(0, (m_st == 1) ? 19 : 3) == 0) begin
                start = 1; prog_count = CW'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 1) == 1) begin
                memwrite = 1;
                if (m_st == 1 && $urandom_range(0, 1) == 1) begin
                    dataadr   = ta[m_mc];
                    writedata = ($urandom_range(0, 3) == 0) ? (td[m_mc] ^ 32'd1) : td[m_mc];
                end else begin
                    dataadr   = pick_addr();
                    writedata = $urandom_range(0, 3);
                end
            end
            tick();
        end
        idle_in();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/store_check_monitor.md
# store_check_monitor

Synthesizable store-stream checker for the single-cycle MIPS CPU: it watches the CPU's data-memory write port (memwrite/dataadr/writedata) and compares stores against a programmable in-order table of expected (address, data) pairs. It generalises our single-target self-check:
- DEPTH expected stores instead of one.
- A parametrised ignored scratch address.
- A cycle-timeout watchdog.
- Sticky pass/fail status with a failure code and captured offending store.

It sits beside the cpu in simulation and FPGA bring-up, driving status LEDs or a bench.

## Interface
- DATA_W, 32, width of writedata and expected data
- ADDR_W, 32, width of dataadr and expected address
- DEPTH, 8, expected-store table entries (>=1)
- IGNORE_ADDR, 80, store address silently ignored while running
- TIMEOUT, 1000, max RUN cycles before failing (>=2)
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; returns block to IDLE, clears table count and status
- prog_we  in  1  write table entry prog_idx (IDLE only)
- prog_idx  in  $clog2(DEPTH)  table entry index
- prog_addr  in  ADDR_W  expected store address
- prog_data  in  DATA_W  expected store data
- prog_count  in  $clog2(DEPTH+1)  number of valid entries, sampled on start; values >DEPTH clamp to DEPTH
- start  in  1  begin a check run (IDLE, PASS or FAIL)
- memwrite  in  1  CPU store strobe
- dataadr  in  ADDR_W  CPU store address
- writedata  in  DATA_W  CPU store data
- busy  out  1  in RUN
- pass  out  1  sticky success
- fail  out  1  sticky failure
- fail_code  out  2  0 none, 1 unexpected address, 2 data mismatch, 3 timeout
- match_cnt  out  $clog2(DEPTH+1)  expected stores matched so far
- err_adr  out  ADDR_W  captured address of failing store
- err_data  out  DATA_W  captured data of failing store
- cycles  out  $clog2(TIMEOUT+1)  RUN cycles elapsed

## Operation
- States:
  - IDLE: reset state; table writable.
  - RUN: checking active.
  - PASS, FAIL: terminal; sticky until start or reset.
- Reset values: busy, pass, fail, fail_code, match_cnt, err_adr, err_data, cycles all 0; state IDLE. Table contents are not cleared and don't care.
- IDLE/PASS/FAIL + start with clamped count >0 -> RUN. On that edge, clear match_cnt, cycles, pass, fail, fail_code, err_adr, err_data and latch the count.
- start with count 0 is ignored; state is unchanged.
- prog_we is honoured only outside RUN; it is ignored in RUN. start in RUN is ignored.
- In RUN, each cycle with memwrite=1, evaluated in this priority order:
  - dataadr==exp_addr[match_cnt] and writedata==exp_data[match_cnt]: match_cnt+1. If match_cnt+1 equals the count -> PASS.
  - dataadr==exp_addr[match_cnt], data differs: FAIL, code 2.
  - dataadr==IGNORE_ADDR: no effect.
  - Otherwise: FAIL, code 1.
  - On either failure, err_adr/err_data capture dataadr/writedata.
- An expected entry equal to IGNORE_ADDR is matched as an expected store (the first rule wins).
- memwrite outside RUN is ignored.
- cycles increments every RUN cycle and saturates.
- Timeout: if a RUN cycle begins with cycles==TIMEOUT-1 and PASS is not reached in that cycle -> FAIL, code 3, err_* unchanged at 0.
- Simultaneous events: a final match or a store failure in the timeout cycle takes precedence over the timeout.
- Reset during RUN: next edge IDLE, all status cleared, latched count cleared.

## Timing
- All outputs are registered. A store sampled at edge N is reflected in pass/fail/match_cnt/err_* after edge N; no combinational path from inputs to outputs.
- busy rises the cycle after the start edge and falls the cycle after the terminal decision.
- One store is evaluated per cycle; back-to-back stores on consecutive cycles are supported.
- Timeout fail asserts exactly TIMEOUT cycles after the start edge.

## Test plan
- Table {(84,7)}, count 1, start. Stores (80,5) then (84,7) on consecutive cycles -> pass=1, match_cnt=1, fail_code=0, busy=0 one cycle after the second store.
- Same table, store (84,6) -> fail=1, fail_code=2, err_adr=84, err_data=6. Further stores are ignored and the status stays sticky.
- Same table, store (88,7) -> fail_code=1, err_adr=88. Then start again with store (84,7) -> status clears on start, then pass=1.
- TIMEOUT=16, table {(84,7)}, no stores -> fail=1, fail_code=3 exactly 16 cycles after start; cycles=16.
- TIMEOUT=16, final (84,7) store in cycle 16 -> pass=1, not timeout.
- DEPTH=4, table {(0,1),(4,2),(8,3)}, count 3. Store (0,1),(4,2), then reset, then start, then (0,1),(4,2),(8,3) -> after reset: IDLE, match_cnt=0; final pass=1, match_cnt=3.
- prog_we in RUN overwriting entry 0 with (0,9) -> table unchanged; store (0,1) still matches.
